// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the Q20.16 sequential divider (div_36_seq) and any
//   wrapper that instantiates it.
//
//   Contents:
//     WIDTH    operand/result width (two's complement)
//     FRAC     number of fractional bits
//     ITER     restoring-division iterations: WIDTH + FRAC + 1. The extra
//              iteration produces the half bit that drives rounding.
//     MAX_POS  saturation value for positive overflow / x/0 with x >= 0
//     MAX_NEG  saturation value for negative overflow / x/0 with x < 0
//     state_t  controller states
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned ITER  = WIDTH + FRAC + 1;

    localparam logic [35:0] MAX_POS = 36'h7FFFFFFFF;
    localparam logic [35:0] MAX_NEG = 36'h800000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage : div_pkg

// File: rtl/div_36_seq.sv
// ---------------------------------------------------------------------------
// div_36_seq
//   Sequential signed fixed-point divider, result = dataa / datab, Q20.16.
//   Restoring division producing one quotient bit per clock, then
//   round-half-away-from-zero and saturation. Fixed latency: out_valid rises
//   on the 55th clock edge counting the accepting edge as the first
//   (accept, 53 CALC edges, FINISH edge), for every operand pair.
//
//   Ports:
//     clk          clock
//     reset_n      synchronous active-low reset
//     in_valid     operands valid
//     in_ready     block can accept operands (only in IDLE)
//     dataa        dividend, Q20.16
//     datab        divisor,  Q20.16
//     out_valid    result valid, held until out_ready
//     out_ready    consumer accepts result
//     result       quotient, Q20.16 (held after the handshake)
//     div_by_zero  datab was zero; qualified by out_valid
//     overflow     quotient saturated; qualified by out_valid
// ---------------------------------------------------------------------------
module div_36_seq #(
    parameter int unsigned WIDTH = div_pkg::WIDTH,
    parameter int unsigned FRAC  = div_pkg::FRAC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             overflow
);

    import div_pkg::state_t;
    import div_pkg::IDLE;
    import div_pkg::CALC;
    import div_pkg::FINISH;
    import div_pkg::DONE;

    // Derived widths
    localparam int unsigned N_ITER = WIDTH + FRAC + 1;     // quotient bits
    localparam int unsigned QW     = N_ITER;               // quotient / numerator width
    localparam int unsigned RW     = WIDTH + 1;            // remainder width
    localparam int unsigned CW     = $clog2(N_ITER);       // iteration counter width

    // Saturation values and the rounded-magnitude limits they guard
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [QW-1:0]    LIM_POS = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [QW-1:0]    LIM_NEG = LIM_POS + {{(QW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(N_ITER - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    logic             sign_q;       // quotient sign
    logic             asign_q;      // dividend sign, selects x/0 saturation
    logic             zero_q;       // divisor was zero
    logic [RW-1:0]    dvs_q;        // |datab|, exact for the most negative value
    logic [QW-1:0]    num_q;        // {|dataa|, FRAC zeros, half-bit zero}, MSB first
    logic [RW-1:0]    rem_q;        // partial remainder
    logic [QW-1:0]    quo_q;        // quotient bits, last one is the half bit
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             dz_q;
    logic             ov_q;

    // ------------------------------------------------------------------
    // Operand magnitudes. Negating the most negative value wraps to itself,
    // which read as unsigned is exactly 2^(WIDTH-1).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_mag = dataa[WIDTH-1] ? (~dataa + 1'b1) : dataa;
        b_mag = datab[WIDTH-1] ? (~datab + 1'b1) : datab;
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [RW:0]   rem_shift;
    logic [RW:0]   dvs_ext;
    logic [RW:0]   rem_diff;
    logic          q_bit;
    logic [RW-1:0] rem_d;
    logic [QW-1:0] quo_d;
    logic [QW-1:0] num_d;

    always_comb begin
        rem_shift = {rem_q, num_q[QW-1]};
        dvs_ext   = {1'b0, dvs_q};
        rem_diff  = rem_shift - dvs_ext;
        q_bit     = (rem_shift >= dvs_ext);
        // The kept remainder is always below the divisor, so it fits in RW.
        rem_d     = RW'(q_bit ? rem_diff : rem_shift);
        quo_d     = {quo_q[QW-2:0], q_bit};
        num_d     = {num_q[QW-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Rounding and saturation. The quotient carries one bit below the LSB;
    // adding it to the truncated magnitude rounds half away from zero
    // because the sign is reapplied afterwards.
    // ------------------------------------------------------------------
    logic [QW-1:0]    q_round;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] fin_res;
    logic             fin_dz;
    logic             fin_ov;

    always_comb begin
        q_round = {1'b0, quo_q[QW-1:1]} + {{(QW-1){1'b0}}, quo_q[0]};
        q_mag   = q_round[WIDTH-1:0];
        fin_dz  = 1'b0;
        fin_ov  = 1'b0;
        fin_res = sign_q ? (~q_mag + 1'b1) : q_mag;
        if (zero_q) begin
            fin_dz  = 1'b1;
            fin_res = asign_q ? SAT_NEG : SAT_POS;
        end else if (q_round > (sign_q ? LIM_NEG : LIM_POS)) begin
            fin_ov  = 1'b1;
            fin_res = sign_q ? SAT_NEG : SAT_POS;
        end
    end

    // ------------------------------------------------------------------
    // Controller and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            asign_q     <= 1'b0;
            zero_q      <= 1'b0;
            dvs_q       <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_q     <= dataa[WIDTH-1] ^ datab[WIDTH-1];
                        asign_q    <= dataa[WIDTH-1];
                        zero_q     <= (datab == '0);
                        dvs_q      <= {1'b0, b_mag};
                        num_q      <= {a_mag, {FRAC{1'b0}}, 1'b0};
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end

                // Runs the full iteration count even for a zero divisor so
                // the latency never depends on the operands.
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    num_q <= num_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FINISH;
                    end
                end

                FINISH: begin
                    result_q    <= fin_res;
                    dz_q        <= fin_dz;
                    ov_q        <= fin_ov;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule : div_36_seq

// File: tb/tb_div_36_seq.sv
// ---------------------------------------------------------------------------
// tb_div_36_seq
//   Self-checking bench for div_36_seq: a table of known quotients, a few
//   operands checked against an integer reference model, plus hand-written
//   sequences for output back-pressure and reset during CALC.
// ---------------------------------------------------------------------------
module tb_div_36_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] dataa;
    logic [35:0] datab;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] result;
    logic        div_by_zero;
    logic        overflow;

    always #5 clk = ~clk;

    div_36_seq #(
        .WIDTH (36),
        .FRAC  (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataa       (dataa),
        .datab       (datab),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [35:0] a;
        logic [35:0] b;
        logic [35:0] res;
        logic        dz;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [35:0] res;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: round(|a| * 2^16 / |b|) computed as floor(2x)+1 >> 1 in
    // 64-bit integers, then saturate and reapply the sign.
    function automatic exp_t model(input logic [35:0] a, input logic [35:0] b);
        exp_t   e;
        longint sa, sbv, ma, mb, t, r, lim;
        logic   neg;
        sa  = longint'(signed'(a));
        sbv = longint'(signed'(b));
        ma  = (sa  < 0) ? -sa  : sa;
        mb  = (sbv < 0) ? -sbv : sbv;
        neg = (sa < 0) != (sbv < 0);
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (mb == 0) begin
            e.dz  = 1'b1;
            e.res = (sa < 0) ? 36'h800000000 : 36'h7FFFFFFFF;
        end else begin
            t   = (ma <<< 17) / mb;
            r   = (t + 1) >>> 1;
            lim = neg ? 64'sh800000000 : 64'sh7FFFFFFFF;
            if (r > lim) begin
                e.ov  = 1'b1;
                e.res = neg ? 36'h800000000 : 36'h7FFFFFFFF;
            end else begin
                e.res = neg ? 36'(-r) : 36'(r);
            end
        end
        return e;
    endfunction

    // Issue one division, check latency and result, optionally hold off
    // out_ready for 'hold' cycles, then complete the output handshake.
    task automatic run_div(input logic [35:0] a, input logic [35:0] b,
                           input exp_t e, input int id, input int hold);
        int   n;
        exp_t x;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("v%0d in_ready_before_accept", id), 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dataa    = a;
        datab    = b;
        sb.push_back(e);
        vectors++;
        @(posedge clk); #1;             // accepting edge = edge 1
        in_valid = 1'b0;
        dataa    = {4'($urandom_range(15, 0)), 32'($urandom)};
        datab    = {4'($urandom_range(15, 0)), 32'($urandom)};
        check($sformatf("v%0d in_ready_busy", id), 64'(in_ready), 64'd0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("v%0d latency_edges", id), 64'(n), 64'd55);
        check($sformatf("v%0d out_valid", id), 64'(out_valid), 64'd1);
        x = sb.pop_front();
        check($sformatf("v%0d result", id), 64'(result), 64'(x.res));
        check($sformatf("v%0d div_by_zero", id), 64'(div_by_zero), 64'(x.dz));
        check($sformatf("v%0d overflow", id), 64'(overflow), 64'(x.ov));
        for (int h = 0; h < hold; h++) begin
            // Offer new operands; they must be ignored while DONE.
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("v%0d hold%0d result", id, h), 64'(result), 64'(x.res));
            check($sformatf("v%0d hold%0d out_valid", id, h), 64'(out_valid), 64'd1);
            check($sformatf("v%0d hold%0d in_ready", id, h), 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d out_valid_after_hs", id), 64'(out_valid), 64'd0);
        check($sformatf("v%0d in_ready_after_hs", id), 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[16];
        exp_t        e;
        logic [35:0] ra, rb;
        int          seen;

        tbl[0]  = '{36'h000010000, 36'h000020000, 36'h000008000, 1'b0, 1'b0};
        tbl[1]  = '{36'h000010000, 36'h000030000, 36'h000005555, 1'b0, 1'b0};
        tbl[2]  = '{36'h000020000, 36'h000030000, 36'h00000AAAB, 1'b0, 1'b0};
        tbl[3]  = '{36'hFFFFE0000, 36'h000030000, 36'hFFFFF5555, 1'b0, 1'b0};
        tbl[4]  = '{36'hFFFFD0000, 36'h000020000, 36'hFFFFE8000, 1'b0, 1'b0};
        tbl[5]  = '{36'hFFFFD0000, 36'hFFFFE0000, 36'h000018000, 1'b0, 1'b0};
        tbl[6]  = '{36'h000050000, 36'h000000000, 36'h7FFFFFFFF, 1'b1, 1'b0};
        tbl[7]  = '{36'hFFFFB0000, 36'h000000000, 36'h800000000, 1'b1, 1'b0};
        tbl[8]  = '{36'h7FFFFFFFF, 36'h000000001, 36'h7FFFFFFFF, 1'b0, 1'b1};
        tbl[9]  = '{36'h800000000, 36'h000000001, 36'h800000000, 1'b0, 1'b1};
        tbl[10] = '{36'h000000000, 36'h000030000, 36'h000000000, 1'b0, 1'b0};
        tbl[11] = '{36'h800000000, 36'h800000000, 36'h000010000, 1'b0, 1'b0};
        tbl[12] = '{36'h800000000, 36'h000010000, 36'h800000000, 1'b0, 1'b0};
        tbl[13] = '{36'h7FFFFFFFF, 36'h000010000, 36'h7FFFFFFFF, 1'b0, 1'b0};
        tbl[14] = '{36'h000000001, 36'h000020000, 36'h000000001, 1'b0, 1'b0};
        tbl[15] = '{36'hFFFFFFFFF, 36'h000020000, 36'hFFFFFFFFF, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dataa     = '0;
        datab     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            e.res = tbl[i].res;
            e.dz  = tbl[i].dz;
            e.ov  = tbl[i].ov;
            run_div(tbl[i].a, tbl[i].b, e, i, 0);
        end

        for (int i = 0; i < 8; i++) begin
            ra = {4'($urandom_range(15, 0)), 32'($urandom)};
            rb = {4'($urandom_range(15, 0)), 32'($urandom)};
            if (i >= 4) rb = 36'(signed'(rb) >>> 12);
            run_div(ra, rb, model(ra, rb), 100 + i, 0);
        end

        // Back-pressure: result must hold for 10 cycles with out_ready low.
        e.res = 36'h000005555; e.dz = 1'b0; e.ov = 1'b0;
        run_div(36'h000010000, 36'h000030000, e, 200, 10);

        // Reset at CALC cycle 20 abandons the operation.
        in_valid = 1'b1;
        dataa    = 36'h000050000;
        datab    = 36'h000020000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midreset no_output", 64'(seen), 64'd0);

        e.res = 36'hFFFFE8000; e.dz = 1'b0; e.ov = 1'b0;
        run_div(36'hFFFFD0000, 36'h000020000, e, 300, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_div_36_seq

// File: doc/div_36_seq.md
Name: div_36_seq

Overview:
- Sequential signed fixed-point divider for the 36-bit Q20.16 format used by the matrix datapath. It is the inverse operation of the element-wise multiplier array.
- Computes result = dataa / datab, one quotient bit per cycle, with round-half-away-from-zero and saturation.
- Feeds the IK solver's reciprocal and normalisation steps through a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 36, operand and result width (two's complement).
- FRAC, 16, number of fractional bits.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dataa  input  WIDTH  dividend, Q20.16.
- datab  input  WIDTH  divisor, Q20.16.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  quotient, Q20.16.
- div_by_zero  output  1  datab was 0; qualified by out_valid.
- overflow  output  1  quotient saturated; qualified by out_valid.

Behaviour:
- Reset: reset_n sampled low at a clk edge puts the block in IDLE with in_ready=1, out_valid=0, result=0, div_by_zero=0, overflow=0, and clears the iteration counter. Reset mid-CALC or mid-DONE abandons the operation; no result is ever emitted for it.
- States: IDLE, CALC, FINISH, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch sign = dataa[35]^datab[35], magnitudes |dataa| and |datab| (37-bit so that -2^35 is exact), numerator N = |dataa|<<FRAC (52 bits), counter=0, zero flag = (datab==0). Next state is CALC.
- CALC: in_ready=0. Runs restoring division, one bit per cycle, on {N, one extra zero bit} for ITER = WIDTH+FRAC+1 = 53 cycles.
  - Each cycle: shift remainder left, bring in the next numerator bit, subtract divisor if the remainder is >= divisor, and shift the resulting quotient bit in.
  - After the counter reaches ITER-1, the next state is FINISH.
- FINISH, one cycle. Rounding and saturation:
  - q_round = q[52:1] + q[0], i.e. the extra bit is the half bit.
  - Positive limit is 2^35-1. Negative limit is 2^35 in magnitude.
  - If zero flag is set: result = sign of dataa ? 0x800000000 : 0x7FFFFFFFF, div_by_zero=1, overflow=0.
  - Else if q_round exceeds the limit for its sign: result = 0x7FFFFFFFF (positive) or 0x800000000 (negative), overflow=1.
  - Else: result = sign ? -q_round : q_round.
  - Result and flags are registered and out_valid is set to 1; the next state is DONE.
- Fixed latency: out_valid rises exactly 55 clk edges after the accepting edge (1 latch edge, 53 CALC edges, 1 FINISH edge). This holds for all operands, including divide-by-zero, whose CALC result is discarded.
- DONE: out_valid=1. result and flags are held stable until out_valid&out_ready. On that edge, out_valid goes to 0 and the state returns to IDLE; in_ready returns to 1 the following cycle. No accept is possible while in DONE.
- Flags and result keep their last values after the handshake. Consumers must qualify them with out_valid.
- Throughput: one division per 56 cycles minimum.
- in_valid while in_ready=0 is ignored. The upstream holds dataa/datab only until accept.

Decomposition:
- Shared package div_pkg:
  - WIDTH, FRAC and ITER constants.
  - MAX_POS = 36'h7FFFFFFFF and MAX_NEG = 36'h800000000.
  - The state typedef enum {IDLE, CALC, FINISH, DONE}.
- No sub-module: a single FSM plus the shift/subtract datapath.
- A later div_array wrapper instantiates n×n copies for element-wise matrix division. It is outside the scope of this block.

Test Plan:
- 1.0/2.0: dataa=0x000010000, datab=0x000020000 -> result 0x000008000, flags 0, out_valid exactly 55 edges after accept.
- Rounding: 0x000010000/0x000030000 -> 0x000005555; 0x000020000/0x000030000 -> 0x00000AAAB; -2/3, i.e. 0xFFFFE0000/0x000030000 -> 0xFFFFF5555.
- Sign: 0xFFFFD0000 (-3.0) / 0x000020000 -> 0xFFFFE8000 (-1.5); -3.0/-2.0 -> 0x000018000.
- Divide by zero: 0x000050000/0 -> 0x7FFFFFFFF, div_by_zero=1; 0xFFFFB0000/0 -> 0x800000000, div_by_zero=1; both with 55-edge latency.
- Overflow: 0x7FFFFFFFF/0x000000001 -> 0x7FFFFFFFF, overflow=1; 0x800000000/0x000000001 -> 0x800000000, overflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0; the accept then returns to IDLE.
  - Pulse reset_n low at CALC cycle 20 -> out_valid stays 0 and in_ready=1 the cycle after reset releases; the next division is correct.
